// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential increment, redirect, stall hold, and an
// optional return-address stack built only when PC_UNIT_RAS_EN is defined.
module pc_unit #(
    parameter int unsigned    WIDTH     = 16,
    parameter int unsigned    INC       = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned    RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next,
    output logic             ras_empty,
    output logic             ras_full
);

    logic [WIDTH-1:0] seq;
    logic             ret_hit;
    logic [WIDTH-1:0] ret_target;

    assign seq = pc_out + WIDTH'(INC);

    // Next-PC priority: flush beats stall, stall beats predicted return.
    always_comb begin
        pc_next = seq;
        if (redirect)
            pc_next = redirect_pc;
        else if (stall)
            pc_next = pc_out;
        else if (ret_hit)
            pc_next = ret_target;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc_out <= RESET_VEC;
        else
            pc_out <= pc_next;
    end

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    tos, tos_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             has, upd, push, pop, swap;

    // tos points at the live top; pushing past full wraps onto the oldest slot.
    always_comb begin
        has   = (cnt != '0);
        upd   = !redirect && !stall;
        swap  = upd && call && ret && has;
        push  = upd && call && !swap;
        pop   = upd && ret && !call && has;
        tos_n = tos;
        cnt_n = cnt;
        if (push) begin
            tos_n = tos + PW'(1);
            if (cnt != CW'(RAS_DEPTH))
                cnt_n = cnt + CW'(1);
        end else if (pop) begin
            tos_n = tos - PW'(1);
            cnt_n = cnt - CW'(1);
        end
    end

    assign ret_hit    = ret && has;
    assign ret_target = ras[tos];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos       <= '0;
            cnt       <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
        end else begin
            tos       <= tos_n;
            cnt       <= cnt_n;
            ras_empty <= (cnt_n == '0);
            ras_full  <= (cnt_n == CW'(RAS_DEPTH));
        end
    end

    // Storage is not reset; cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            ras[tos_n] <= seq;
        else if (swap)
            ras[tos] <= seq;
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{call, ret};
    assign ret_hit    = 1'b0;
    assign ret_target = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It replaces the fixed 16-bit stallable PC register with a configurable-width PC that has:
- a sequential increment;
- a taken-branch/jump redirect;
- a stall hold;
- an optional return-address stack (RAS) that predicts `ret` targets.

It feeds the instruction-memory address and the IF/ID pipeline register.

## Interface

Parameters:
- `WIDTH`, 16: PC width in bits.
- `INC`, 2: sequential increment, in bytes.
- `RESET_VEC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: RAS entries; must be a power of two, at least 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `stall`  in  1  hold the PC and the RAS (hazard unit).
- `redirect`  in  1  taken branch/jump resolved in execute.
- `redirect_pc`  in  WIDTH  redirect target.
- `call`  in  1  fetch-stage predecode: the current instruction is a call.
- `ret`  in  1  fetch-stage predecode: the current instruction is a return.
- `pc_out`  out  WIDTH  registered current PC.
- `pc_next`  out  WIDTH  combinational value to be loaded at the next edge.
- `ras_empty`  out  1  registered; RAS holds 0 entries.
- `ras_full`  out  1  registered; RAS holds `RAS_DEPTH` entries.

## Operation

- State: `pc_out`, RAS storage array, top-of-stack pointer `tos`, entry count `cnt` (0..`RAS_DEPTH`).
- Define `seq = pc_out + INC`, truncated to `WIDTH` bits; `0xFFFE + 2` wraps to `0x0000` when `WIDTH=16`.
- `pc_next` selection, highest priority first:
  - `redirect`: `redirect_pc`. This applies even when `stall=1`; a flush overrides a stall.
  - `stall`: `pc_out`, held.
  - `ret` and `cnt>0`: `ras[tos]`.
  - otherwise: `seq`.
- The RAS updates only when `redirect=0` and `stall=0`:
  - `call` only: push `seq`; `cnt` increments, saturating at `RAS_DEPTH`.
  - Push when full: the oldest entry is overwritten (circular pointer); `cnt` stays at `RAS_DEPTH`.
  - `ret` only, `cnt>0`: pop; `cnt` decrements.
  - `ret` only, `cnt=0`: no pop, PC takes `seq`, no error flag.
  - `call` and `ret` together, `cnt>0`: next PC is the old top; the top entry is replaced by `seq`; `cnt` is unchanged.
  - `call` and `ret` together, `cnt=0`: treated as `call` only.
- A redirect does not repair or flush the RAS. Any `call`/`ret` presented in a redirect cycle is discarded.
- `ras_empty = (cnt==0)`, `ras_full = (cnt==RAS_DEPTH)`, both derived from registered state.

## Timing

- Reset while `rst=0`, asynchronously and regardless of `clk`:
  - `pc_out = RESET_VEC`
  - `cnt = 0`, `tos = 0`
  - `ras_empty = 1`, `ras_full = 0`
  - RAS contents are not reset.
- Reset mid-operation discards all RAS entries. The first edge after `rst` rises loads `pc_next` as computed from `RESET_VEC`.
- Latency: inputs sampled at edge N appear on `pc_out` after edge N. `pc_next` is valid in the same cycle as its inputs.
- A stall lasting k cycles holds `pc_out` for exactly k edges.
- There is no combinational path from any input to `pc_out` or to the flags.

## Configuration

- `PC_UNIT_RAS_EN` defined:
  - the RAS is built as described above.
- `PC_UNIT_RAS_EN` undefined:
  - no RAS storage, `tos` or `cnt`;
  - `call` and `ret` are ignored, so `pc_next` is `redirect_pc`, `pc_out` or `seq`;
  - `ras_empty` is tied to 1 and `ras_full` is tied to 0;
  - `RAS_DEPTH` is unused.

## Test plan

- Reset and increment: with `rst` low, `pc_out=0x0000`. Release reset with no controls asserted for 3 edges → `pc_out` shows 0x0002, 0x0004, 0x0006.
- Stall versus redirect: with `pc_out=0x0010`, hold `stall=1` for 2 edges → `pc_out` stays 0x0010. Then assert `stall=1` and `redirect=1` with `redirect_pc=0x0100` → `pc_out=0x0100`.
- Wrap-around: force `pc_out=0xFFFE` via redirect, then 1 sequential edge → `pc_out=0x0000`.
- Call/return: with `pc_out=0x0020`, assert `call` and `redirect` with `redirect_pc=0x0200` → `pc_out=0x0200` and the RAS is unchanged. Then, at `pc_out=0x0020`, a `call` alone → pushes 0x0022. Redirect to 0x0300, then `ret` → `pc_out=0x0022` and `ras_empty=1`.
- Overflow and underflow (`RAS_DEPTH=4`): 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_full=1`. Then 4 rets → 0x52, 0x42, 0x32, 0x22. A 5th `ret` → `seq`, with `ras_empty=1`.
- Simultaneous `call`+`ret` with top=0x0044 at `pc_out=0x0060` → `pc_out=0x0044`, new top=0x0062, `cnt` unchanged. Also assert `rst` mid-sequence → `ras_empty=1` and `pc_out=0x0000` immediately, without waiting for a clock edge.
